// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble, one bit per cycle) feeding
// an 8-digit common-anode multiplexed 7-segment display with leading-zero blanking.
module bcd_display_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [26:0] in_data,
    input  logic        OutOfRange,
    output logic [31:0] bcd_out,
    output logic        busy,
    output logic        conv_done,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int                SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [26:0]       MAX_VAL  = 27'd99999999;
    localparam logic [6:0]        SEG_DASH = 7'b0111111;
    localparam logic [6:0]        SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Double-dabble correction: any nibble >= 5 would overflow a decimal digit after the shift.
    function automatic logic [35:0] add3_all(input logic [35:0] acc);
        logic [35:0] r;
        r = acc;
        for (int k = 0; k < 9; k++) begin
            if (acc[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = acc[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = acc[4*k +: 4];
            end
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [26:0]         value_q, value_d;
    logic                ovf_q, ovf_d;
    logic [35:0]         acc_q, acc_d;
    logic [26:0]         bin_q, bin_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [31:0]         bcd_q, bcd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [62:0]         shifted_s;
    logic                upper_zero_s;
    logic [3:0]          nib_s;

    // Conversion FSM next-state and datapath.
    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        ovf_d     = ovf_q;
        acc_d     = acc_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        shifted_s = {add3_all(acc_q), bin_q} << 1;
        case (state_q)
            IDLE: begin
                if (in_data != value_q) begin
                    value_d = in_data;
                    acc_d   = 36'd0;
                    if (in_data > MAX_VAL) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        ovf_d   = 1'b0;
                        bin_d   = in_data;
                        cnt_d   = 5'd27;
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d = shifted_s[62:27];
                bin_d = shifted_s[26:0];
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                bcd_d   = acc_q[31:0];
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    // Digit scan and segment selection; an/seg are registered from the current index.
    always_comb begin
        if (scan_q == SCAN_MAX) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end else begin
            scan_d = scan_q + SCAN_W'(1);
            idx_d  = idx_q;
        end
        upper_zero_s = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if ((k >= int'(idx_q)) && (bcd_q[4*k +: 4] != 4'd0)) begin
                upper_zero_s = 1'b0;
            end else begin
                upper_zero_s = upper_zero_s;
            end
        end
        nib_s = bcd_q[{idx_q, 2'b00} +: 4];
        an_d  = ~(8'b1 << idx_q);
        if (OutOfRange || ovf_q) begin
            seg_d = SEG_DASH;
        end else if ((idx_q != 3'd0) && upper_zero_s) begin
            seg_d = SEG_OFF;
        end else begin
            seg_d = seg_decode(nib_s);
        end
    end

    // State register for conversion and display.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            value_q <= 27'd0;
            ovf_q   <= 1'b0;
            acc_q   <= 36'd0;
            bin_q   <= 27'd0;
            cnt_q   <= 5'd0;
            bcd_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= 3'd0;
            an_q    <= 8'hFF;
            seg_q   <= SEG_OFF;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign busy      = busy_q;
    assign conv_done = done_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule
